// File: rtl/traceback_unit.sv
// Survivor-path memory and traceback for the K=3, rate-1/2 Viterbi decoder.
// It collects one frame of predecessor decisions, traces back from the best final state, then emits the bits serially.
module traceback_unit #(
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tb,
  input  logic [1:0] prv_st_00,
  input  logic [1:0] prv_st_01,
  input  logic [1:0] prv_st_10,
  input  logic [1:0] prv_st_11,
  input  logic [1:0] sel_node,
  output logic       tb_ready,
  output logic       dec_bit,
  output logic       dec_valid,
  output logic       frame_done,
  output logic       err
);

  // Handshake: en_tb is a one-cycle strobe and is accepted only while tb_ready is high.
  // An en_tb that arrives while tb_ready is low is dropped and sets the sticky err flag.

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TRACE = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             cur_st_q, cur_st_d;
  logic [FRAME_LEN-1:0]   bits_q, bits_d;
  logic                   dec_bit_q, dec_bit_d;
  logic                   dec_valid_q, dec_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_q, err_d;
  logic                   mem_we;
  logic [1:0]             mem_q [FRAME_LEN][4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // OUT holds one extra cycle after the last bit so the registered last output drains before FILL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:  if (en_tb && (cnt_q == LAST)) state_d = ST_TRACE;
      ST_TRACE: if (cnt_q == ZERO) state_d = ST_OUT;
      ST_OUT:   if (frame_done_q) state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  assign tb_ready = (state_q == ST_FILL);

  always_comb begin
    cnt_d        = cnt_q;
    cur_st_d     = cur_st_q;
    bits_d       = bits_q;
    mem_we       = 1'b0;
    dec_bit_d    = 1'b0;
    dec_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q | (en_tb & ~tb_ready);
    case (state_q)
      ST_FILL: begin
        if (en_tb) begin
          mem_we = 1'b1;
          if (cnt_q == LAST) begin
            cur_st_d = sel_node;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_TRACE: begin
        bits_d[cnt_q] = cur_st_q[1];
        cur_st_d      = mem_q[cnt_q][cur_st_q];
        if (cnt_q != ZERO) cnt_d = cnt_q - ONE;
      end
      ST_OUT: begin
        if (frame_done_q) begin
          cnt_d = ZERO;
        end else begin
          dec_valid_d  = 1'b1;
          dec_bit_d    = bits_q[cnt_q];
          frame_done_d = (cnt_q == LAST);
          if (cnt_q != LAST) cnt_d = cnt_q + ONE;
        end
      end
      default: cnt_d = ZERO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= ZERO;
      cur_st_q     <= 2'b00;
      bits_q       <= '0;
      dec_bit_q    <= 1'b0;
      dec_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cur_st_q     <= cur_st_d;
      bits_q       <= bits_d;
      dec_bit_q    <= dec_bit_d;
      dec_valid_q  <= dec_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Survivor memory needs no reset: every entry is rewritten before it is traced.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[cnt_q][0] <= prv_st_00;
      mem_q[cnt_q][1] <= prv_st_01;
      mem_q[cnt_q][2] <= prv_st_10;
      mem_q[cnt_q][3] <= prv_st_11;
    end
  end

  assign dec_bit    = dec_bit_q;
  assign dec_valid  = dec_valid_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: a FRAME_LEN=4 instance for most scenarios plus a FRAME_LEN=16 instance for the all-zero frame.
module tb_traceback_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en4, en16;
  logic [1:0] p00, p01, p10, p11, sel;
  logic       rdy4, bit4, val4, fd4, err4;
  logic       rdy16, bit16, val16, fd16, err16;

  int         total, bad;
  int         fd4_cnt, fd16_cnt;
  logic [1:0] exp4_q[$];
  logic [1:0] exp16_q[$];
  logic [1:0] e4, e16;

  always #5 clk = ~clk;

  traceback_unit #(.FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .en_tb(en4),
    .prv_st_00(p00), .prv_st_01(p01), .prv_st_10(p10), .prv_st_11(p11),
    .sel_node(sel), .tb_ready(rdy4), .dec_bit(bit4), .dec_valid(val4),
    .frame_done(fd4), .err(err4)
  );

  traceback_unit #(.FRAME_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .en_tb(en16),
    .prv_st_00(p00), .prv_st_01(p01), .prv_st_10(p10), .prv_st_11(p11),
    .sel_node(sel), .tb_ready(rdy16), .dec_bit(bit16), .dec_valid(val16),
    .frame_done(fd16), .err(err16)
  );

  // Output monitors: each expected entry is {frame_done, dec_bit}.
  always @(negedge clk) begin
    if (!rst) begin
      if (val4) begin
        total++;
        if (exp4_q.size() == 0) begin
          bad++;
          $display("FAIL out4_unexpected got {fd,bit}=%0b%0b want nothing", fd4, bit4);
        end else begin
          e4 = exp4_q.pop_front();
          if ({fd4, bit4} !== e4) begin
            bad++;
            $display("FAIL out4_bit got {fd,bit}=%0b%0b want %0b", fd4, bit4, e4);
          end
        end
      end else if (fd4) begin
        total++;
        bad++;
        $display("FAIL out4_fd_without_valid got fd=1 want 0");
      end
      if (fd4) fd4_cnt++;
      if (val16) begin
        total++;
        if (exp16_q.size() == 0) begin
          bad++;
          $display("FAIL out16_unexpected got {fd,bit}=%0b%0b want nothing", fd16, bit16);
        end else begin
          e16 = exp16_q.pop_front();
          if ({fd16, bit16} !== e16) begin
            bad++;
            $display("FAIL out16_bit got {fd,bit}=%0b%0b want %0b", fd16, bit16, e16);
          end
        end
      end
      if (fd16) fd16_cnt++;
    end
  end

  task automatic wait_ready4();
    for (int i = 0; i < 100; i++) begin
      if (rdy4) break;
      @(negedge clk);
    end
    total++;
    if (rdy4 !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready4 got tb_ready=%0b want 1 within 100 cycles", rdy4);
    end
  endtask

  // Builds a frame whose true encoder path carries data bits b; the decoder must return b.
  task automatic drive4(input logic [3:0] b);
    logic [1:0] s, prev;
    prev = 2'b00;
    for (int t = 0; t < 4; t++) begin
      s   = {b[t], prev[1]};
      en4 = 1'b1;
      p00 = 2'($urandom_range(0, 3));
      p01 = 2'($urandom_range(0, 3));
      p10 = 2'($urandom_range(0, 3));
      p11 = 2'($urandom_range(0, 3));
      case (s)
        2'b00:   p00 = prev;
        2'b01:   p01 = prev;
        2'b10:   p10 = prev;
        default: p11 = prev;
      endcase
      sel = (t == 3) ? s : 2'($urandom_range(0, 3));
      exp4_q.push_back({(t == 3), b[t]});
      prev = s;
      @(negedge clk);
    end
    en4 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] b);
    wait_ready4();
    drive4(b);
  endtask

  task automatic wait_drain4(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp4_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp4_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got %0d pending outputs want 0", name, exp4_q.size());
      exp4_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if ({rdy4, val4, bit4, fd4, err4} !== 5'b10000) begin
      bad++;
      $display("FAIL reset4 got {rdy,val,bit,fd,err}=%05b want 10000", {rdy4, val4, bit4, fd4, err4});
    end
    total++;
    if ({rdy16, val16, bit16, fd16, err16} !== 5'b10000) begin
      bad++;
      $display("FAIL reset16 got {rdy,val,bit,fd,err}=%05b want 10000", {rdy16, val16, bit16, fd16, err16});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_zero16();
    int fdb;
    fdb = fd16_cnt;
    for (int t = 0; t < 16; t++) begin
      en16 = 1'b1;
      {p00, p01, p10, p11, sel} = '0;
      exp16_q.push_back({(t == 15), 1'b0});
      @(negedge clk);
    end
    en16 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp16_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp16_q.size() != 0) begin
      bad++;
      $display("FAIL all_zero16_drain got %0d pending want 0", exp16_q.size());
    end
    total++;
    if (fd16_cnt - fdb != 1) begin
      bad++;
      $display("FAIL all_zero16_fd got %0d pulses want 1", fd16_cnt - fdb);
    end
  endtask

  task automatic test_known_path();
    wait_ready4();
    for (int t = 0; t < 4; t++) begin
      en4 = 1'b1;
      {p00, p01, p10, p11} = '0;
      case (t)
        0:       p10 = 2'b00;
        1:       p01 = 2'b10;
        2:       p10 = 2'b01;
        default: p11 = 2'b10;
      endcase
      sel = (t == 3) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
    en4 = 1'b0;
    exp4_q.push_back(2'b01);
    exp4_q.push_back(2'b00);
    exp4_q.push_back(2'b01);
    exp4_q.push_back(2'b11);
    wait_drain4("known_path");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      send4(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain4("random_frames");
  endtask

  task automatic test_latency();
    int first_val, first_rdy;
    first_val = -1;
    first_rdy = -1;
    send4(4'($urandom_range(0, 15)));
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      if (val4 && first_val < 0) first_val = k;
      if (first_val >= 0 && rdy4 && first_rdy < 0) first_rdy = k;
      if (first_rdy >= 0) break;
    end
    total++;
    if (first_val != 5) begin
      bad++;
      $display("FAIL latency_first_valid got edge T+%0d want T+5", first_val);
    end
    total++;
    if (first_rdy != 9) begin
      bad++;
      $display("FAIL latency_ready got edge T+%0d want T+9", first_rdy);
    end
    wait_drain4("latency");
  endtask

  task automatic test_overflow();
    total++;
    if (err4 !== 1'b0) begin
      bad++;
      $display("FAIL overflow_pre_err got %0b want 0", err4);
    end
    send4(4'($urandom_range(0, 15)));
    @(negedge clk);
    en4 = 1'b1;
    p00 = 2'($urandom_range(0, 3));
    p01 = 2'($urandom_range(0, 3));
    p10 = 2'($urandom_range(0, 3));
    p11 = 2'($urandom_range(0, 3));
    sel = 2'($urandom_range(0, 3));
    @(negedge clk);
    en4 = 1'b0;
    total++;
    if (err4 !== 1'b1) begin
      bad++;
      $display("FAIL overflow_err got %0b want 1", err4);
    end
    wait_drain4("overflow");
    send4(4'($urandom_range(0, 15)));
    wait_drain4("overflow_next");
    total++;
    if (err4 !== 1'b1) begin
      bad++;
      $display("FAIL overflow_err_sticky got %0b want 1", err4);
    end
  endtask

  task automatic test_reset_mid_out();
    int seen;
    seen = 0;
    send4(4'($urandom_range(0, 15)));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (val4) seen++;
      if (seen == 2) break;
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({val4, err4, rdy4, fd4} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_mid_out got {val,err,rdy,fd}=%04b want 0010", {val4, err4, rdy4, fd4});
    end
    exp4_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (val4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_out_quiet got dec_valid=%0b want 0", val4);
    end
    send4(4'($urandom_range(0, 15)));
    wait_drain4("reset_mid_out_next");
  endtask

  task automatic test_back_to_back();
    int fdb;
    fdb = fd4_cnt;
    send4(4'($urandom_range(0, 15)));
    send4(4'($urandom_range(0, 15)));
    wait_drain4("back_to_back");
    total++;
    if (fd4_cnt - fdb != 2) begin
      bad++;
      $display("FAIL back_to_back_fd got %0d pulses want 2", fd4_cnt - fdb);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    fd4_cnt  = 0;
    fd16_cnt = 0;
    en4      = 1'b0;
    en16     = 1'b0;
    {p00, p01, p10, p11, sel} = '0;
    test_reset();
    test_all_zero16();
    test_known_path();
    test_random_frames();
    test_latency();
    test_overflow();
    test_reset_mid_out();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
